// File: rtl/hazard_unit_pkg.sv
// Shared definitions for the pipeline hazard controller: register-address
// defaults, the zero-register constant, the scoreboard entry layout and the
// control-flush FSM encoding.
package hazard_unit_pkg;

  // Default architectural register address width (32 registers).
  localparam int REG_W_DEF = 5;

  // Scoreboard entries carry addresses zero-extended to this width so the
  // entry struct can live here, independent of the REG_W parameter.
  // REG_W must not exceed REG_W_MAX.
  localparam int REG_W_MAX = 8;

  // Width of the control-flush down-counter.
  localparam int CNT_W = 4;

  // Register x0 is hard-wired to zero: never a real producer or consumer.
  localparam logic [REG_W_MAX-1:0] ZERO_REG = '0;

  // One in-flight instruction as seen by the scoreboard.
  typedef struct packed {
    logic                 valid;
    logic [REG_W_MAX-1:0] rd;
    logic                 is_load;
  } sb_entry_t;

  // Control-flush FSM encoding.
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FLUSH = 1'b1
  } ctrl_state_t;

endpackage

// File: rtl/hazard_sb_entry.sv
// One scoreboard stage: a register holding {valid, rd, is_load} that loads
// its input on every clock edge unless the pipeline is frozen.
// Ports: clk/rst (async active-high), hold (freeze), d (next entry), q (entry).
module hazard_sb_entry
  import hazard_unit_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      hold,
  input  sb_entry_t d,
  output sb_entry_t q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (!hold) begin
      q <= d;
    end
  end

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard controller. Tracks the destinations of DEPTH in-flight
// instructions and produces the global stall, the RAW/load-use bubble request,
// per-source forwarding selects and a multi-cycle control flush after jumps.
// Ports: clk/rst (async active-high); decode sources rs1/rs2 (+used), rd
// (+we, is_load); jump_taken; imem_stall/dmem_stall; outputs stall,
// data_hazard, control_hazard, fwd_sel1/fwd_sel2 (0 = register file,
// k = forward from the entry k stages ahead of decode).
module hazard_unit
  import hazard_unit_pkg::*;
#(
  parameter  int REG_W        = REG_W_DEF,
  parameter  int DEPTH        = 2,
  parameter  int FLUSH_CYCLES = 2,
  parameter  int FORWARD_EN   = 1,
  localparam int SEL_W        = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] rs1,
  input  logic [REG_W-1:0] rs2,
  input  logic             rs1_used,
  input  logic             rs2_used,
  input  logic [REG_W-1:0] rd,
  input  logic             rd_we,
  input  logic             rd_is_load,
  input  logic             jump_taken,
  input  logic             imem_stall,
  input  logic             dmem_stall,
  output logic             stall,
  output logic             data_hazard,
  output logic             control_hazard,
  output logic [SEL_W-1:0] fwd_sel1,
  output logic [SEL_W-1:0] fwd_sel2
);

  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(FLUSH_CYCLES - 1);

  logic [REG_W_MAX-1:0] rs1_x;
  logic [REG_W_MAX-1:0] rs2_x;
  logic [REG_W_MAX-1:0] rd_x;

  sb_entry_t sb_d [DEPTH:1];
  sb_entry_t sb_q [DEPTH:1];
  sb_entry_t entry_in;

  logic [DEPTH:1] match1;
  logic [DEPTH:1] match2;
  logic           raw;

  ctrl_state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign rs1_x = REG_W_MAX'(rs1);
  assign rs2_x = REG_W_MAX'(rs2);
  assign rd_x  = REG_W_MAX'(rd);

  assign stall = imem_stall | dmem_stall;

  // An instruction that is being bubbled or squashed must not enter the
  // scoreboard, otherwise younger instructions would wait on a ghost.
  assign entry_in = '{
    valid:   rd_we & (rd_x != ZERO_REG) & ~data_hazard & ~control_hazard,
    rd:      rd_x,
    is_load: rd_is_load
  };

  // Scoreboard shift register: entry 1 takes decode, entry k+1 takes entry k.
  for (genvar k = 1; k <= DEPTH; k++) begin : g_sb
    if (k == 1) begin : g_head
      assign sb_d[k] = entry_in;
    end else begin : g_tail
      assign sb_d[k] = sb_q[k-1];
    end

    hazard_sb_entry u_entry (
      .clk  (clk),
      .rst  (rst),
      .hold (stall),
      .d    (sb_d[k]),
      .q    (sb_q[k])
    );
  end

  always_comb begin
    match1 = '0;
    match2 = '0;
    for (int k = 1; k <= DEPTH; k++) begin
      match1[k] = rs1_used & (rs1_x != ZERO_REG) & sb_q[k].valid & (sb_q[k].rd == rs1_x);
      match2[k] = rs2_used & (rs2_x != ZERO_REG) & sb_q[k].valid & (sb_q[k].rd == rs2_x);
    end
  end

  // With a bypass network only a load one stage ahead is unresolvable; its
  // data is not available until the stage after. Without bypass every match
  // must wait until the producer has left the tracked window.
  always_comb begin
    raw = 1'b0;
    if (FORWARD_EN != 0) begin
      raw = (match1[1] | match2[1]) & sb_q[1].is_load;
    end else begin
      raw = (|match1) | (|match2);
    end
  end

  assign data_hazard = raw & ~control_hazard;

  // Scan oldest to youngest so the youngest matching producer is the final
  // assignment. A load in entry 1 has no data yet and is never a source.
  always_comb begin
    fwd_sel1 = '0;
    fwd_sel2 = '0;
    for (int k = DEPTH; k >= 1; k--) begin
      if (match1[k] && !(k == 1 && sb_q[1].is_load)) begin
        fwd_sel1 = SEL_W'(k);
      end
      if (match2[k] && !(k == 1 && sb_q[1].is_load)) begin
        fwd_sel2 = SEL_W'(k);
      end
    end
    if ((FORWARD_EN == 0) || data_hazard) begin
      fwd_sel1 = '0;
      fwd_sel2 = '0;
    end
  end

  // Control-flush FSM. The jump cycle itself is covered combinationally in
  // IDLE, so the counter only needs FLUSH_CYCLES-1 further cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    control_hazard = jump_taken;
    case (state_q)
      ST_IDLE: begin
        control_hazard = jump_taken;
        // A jump seen during a stall is not latched; the source keeps
        // jump_taken high until the stall drops.
        if (jump_taken && !stall && (FLUSH_CYCLES > 1)) begin
          cnt_d   = RELOAD;
          state_d = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        control_hazard = 1'b1;
        if (!stall) begin
          if (jump_taken) begin
            cnt_d = RELOAD;
          end else begin
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == CNT_W'(1)) begin
              state_d = ST_IDLE;
            end
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit. Instance a: DEPTH=2, FLUSH_CYCLES=3,
// forwarding on. Instance b: DEPTH=3, FLUSH_CYCLES=2, forwarding off.
// Both instances see the same stimulus; each step checks the relevant one.
module tb_hazard_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] rs1, rs2, rd;
  logic       rs1_used, rs2_used, rd_we, rd_is_load;
  logic       jump_taken, imem_stall, dmem_stall;

  logic       stall_a, dh_a, ch_a;
  logic [1:0] sel1_a, sel2_a;
  logic       stall_b, dh_b, ch_b;
  logic [1:0] sel1_b, sel2_b;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  hazard_unit #(.REG_W(5), .DEPTH(2), .FLUSH_CYCLES(3), .FORWARD_EN(1)) u_a (
    .clk(clk), .rst(rst), .rs1(rs1), .rs2(rs2), .rs1_used(rs1_used), .rs2_used(rs2_used),
    .rd(rd), .rd_we(rd_we), .rd_is_load(rd_is_load), .jump_taken(jump_taken),
    .imem_stall(imem_stall), .dmem_stall(dmem_stall), .stall(stall_a),
    .data_hazard(dh_a), .control_hazard(ch_a), .fwd_sel1(sel1_a), .fwd_sel2(sel2_a)
  );

  hazard_unit #(.REG_W(5), .DEPTH(3), .FLUSH_CYCLES(2), .FORWARD_EN(0)) u_b (
    .clk(clk), .rst(rst), .rs1(rs1), .rs2(rs2), .rs1_used(rs1_used), .rs2_used(rs2_used),
    .rd(rd), .rd_we(rd_we), .rd_is_load(rd_is_load), .jump_taken(jump_taken),
    .imem_stall(imem_stall), .dmem_stall(dmem_stall), .stall(stall_b),
    .data_hazard(dh_b), .control_hazard(ch_b), .fwd_sel1(sel1_b), .fwd_sel2(sel2_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs are driven here and
  // outputs are sampled one more time unit later.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rs1 = 5'd0; rs2 = 5'd0; rd = 5'd0;
    rs1_used = 1'b0; rs2_used = 1'b0; rd_we = 1'b0; rd_is_load = 1'b0;
    jump_taken = 1'b0; imem_stall = 1'b0; dmem_stall = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time budget");
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle_inputs();
    rst = 1'b1;
    // During reset: control_hazard follows jump_taken, stall follows memories.
    jump_taken = 1'b1; imem_stall = 1'b1;
    #2;
    chk("rst_ch_follows_jump", ch_a, 1'b1);
    chk("rst_stall", stall_a, 1'b1);
    chk("rst_dh", dh_a, 1'b0);
    chk("rst_sel1", sel1_a, 2'd0);
    jump_taken = 1'b0; imem_stall = 1'b0;
    #1;
    chk("rst_ch_low", ch_a, 1'b0);
    chk("rst_stall_low", stall_b, 1'b0);
    #5 rst = 1'b0;

    // ---- Load-use (a) and no-forward RAW window (b) ----
    cyc(); // C0: load x5
    rd = 5'd5; rd_we = 1'b1; rd_is_load = 1'b1; #1;
    chk("lu_c0_dh", dh_a, 1'b0);
    cyc(); // C1: consumer of x5, load in entry 1
    rd_we = 1'b0; rd_is_load = 1'b0; rs1 = 5'd5; rs1_used = 1'b1; #1;
    chk("lu_c1_dh_a", dh_a, 1'b1);
    chk("lu_c1_sel1_a", sel1_a, 2'd0);
    chk("nf_c1_dh_b", dh_b, 1'b1);
    cyc(); // C2: load now in entry 2
    #1;
    chk("lu_c2_dh_a", dh_a, 1'b0);
    chk("lu_c2_sel1_a", sel1_a, 2'd2);
    chk("nf_c2_dh_b", dh_b, 1'b1);
    chk("nf_c2_sel1_b", sel1_b, 2'd0);
    cyc(); // C3
    #1;
    chk("lu_c3_sel1_a", sel1_a, 2'd0);
    chk("nf_c3_dh_b", dh_b, 1'b1);
    cyc(); // C4: producer has left b's window
    #1;
    chk("nf_c4_dh_b", dh_b, 1'b0);

    // ---- ALU forwarding ----
    cyc(); // C5: ALU write x3
    rs1_used = 1'b0; rd = 5'd3; rd_we = 1'b1; #1;
    cyc(); // C6
    rd_we = 1'b0; rs2 = 5'd3; rs2_used = 1'b1; #1;
    chk("alu_sel2_k1", sel2_a, 2'd1);
    chk("alu_dh_k1", dh_a, 1'b0);
    cyc(); // C7
    #1;
    chk("alu_sel2_k2", sel2_a, 2'd2);
    cyc(); // C8
    #1;
    chk("alu_sel2_gone", sel2_a, 2'd0);
    cyc(); // C9: write to x0
    rs2_used = 1'b0; rd = 5'd0; rd_we = 1'b1; #1;
    cyc(); // C10
    rd_we = 1'b0; rs2 = 5'd0; rs2_used = 1'b1; #1;
    chk("x0_no_fwd", sel2_a, 2'd0);
    cyc(); // C11: two producers of x4 back to back
    rs2_used = 1'b0; rd = 5'd4; rd_we = 1'b1; #1;
    cyc(); // C12
    #1;
    cyc(); // C13: youngest (entry 1) wins
    rd_we = 1'b0; rs1 = 5'd4; rs1_used = 1'b1; #1;
    chk("youngest_wins", sel1_a, 2'd1);

    // ---- Control flush ----
    cyc(); // C14
    idle_inputs(); #1;
    cyc(); // C15: single-cycle jump
    jump_taken = 1'b1; #1;
    chk("fl_c0_a", ch_a, 1'b1);
    chk("fl_c0_b", ch_b, 1'b1);
    cyc(); // C16
    jump_taken = 1'b0; #1;
    chk("fl_c1_a", ch_a, 1'b1);
    chk("fl_c1_b", ch_b, 1'b1);
    cyc(); // C17
    #1;
    chk("fl_c2_a", ch_a, 1'b1);
    chk("fl_c2_b_done", ch_b, 1'b0);
    cyc(); // C18
    #1;
    chk("fl_c3_a_done", ch_a, 1'b0);

    cyc(); // C19: load x6
    rd = 5'd6; rd_we = 1'b1; rd_is_load = 1'b1; #1;
    cyc(); // C20: load-use match plus jump
    rd_we = 1'b0; rd_is_load = 1'b0; rs1 = 5'd6; rs1_used = 1'b1; jump_taken = 1'b1; #1;
    chk("fls_c0_ch", ch_a, 1'b1);
    chk("fls_c0_dh_masked", dh_a, 1'b0);
    cyc(); // C21: data memory stall for two cycles mid-window
    rs1_used = 1'b0; jump_taken = 1'b0; dmem_stall = 1'b1; #1;
    chk("fls_c1_ch", ch_a, 1'b1);
    chk("fls_c1_stall", stall_a, 1'b1);
    cyc(); // C22
    #1;
    chk("fls_c2_ch", ch_a, 1'b1);
    cyc(); // C23
    dmem_stall = 1'b0; #1;
    chk("fls_c3_ch", ch_a, 1'b1);
    cyc(); // C24
    #1;
    chk("fls_c4_ch", ch_a, 1'b1);
    chk("fls_c4_ch_b", ch_b, 1'b0);
    cyc(); // C25
    #1;
    chk("fls_c5_ch_done", ch_a, 1'b0);

    // ---- Stall hold ----
    cyc(); // C26: ALU write x9
    rd = 5'd9; rd_we = 1'b1; #1;
    cyc(); // C27: freeze for four cycles
    rd_we = 1'b0; rs1 = 5'd9; rs1_used = 1'b1; imem_stall = 1'b1; #1;
    for (int i = 0; i < 4; i++) begin
      chk("hold_sel1", sel1_a, 2'd1);
      chk("hold_stall", stall_a, 1'b1);
      if (i == 1) begin
        jump_taken = 1'b1; #1;
        chk("hold_jump_comb", ch_a, 1'b1);
      end
      cyc();
      jump_taken = 1'b0;
      if (i == 3) imem_stall = 1'b0;
      #1;
    end
    // C31: stall released; a jump seen only during the stall left no flush.
    chk("hold_no_flush", ch_a, 1'b0);
    chk("hold_release_sel1", sel1_a, 2'd1);
    cyc(); // C32: shifting resumed
    #1;
    chk("resume_sel1", sel1_a, 2'd2);

    // ---- Asynchronous reset mid-flush ----
    cyc(); // C33: ALU write x8
    rs1_used = 1'b0; rd = 5'd8; rd_we = 1'b1; #1;
    cyc(); // C34: consumer of x8 plus jump
    rd_we = 1'b0; rs2 = 5'd8; rs2_used = 1'b1; jump_taken = 1'b1; #1;
    chk("ar_sel2_k1", sel2_a, 2'd1);
    cyc(); // C35
    jump_taken = 1'b0; #1;
    chk("ar_pre_ch", ch_a, 1'b1);
    chk("ar_pre_sel2", sel2_a, 2'd2);
    #3 rst = 1'b1;
    #1;
    chk("ar_ch", ch_a, 1'b0);
    chk("ar_dh", dh_a, 1'b0);
    chk("ar_sel2", sel2_a, 2'd0);
    #2 rst = 1'b0;
    cyc(); // C36
    #1;
    chk("ar_post_ch", ch_a, 1'b0);
    chk("ar_post_sel2", sel2_a, 2'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
